// File: rtl/tc_pkg.sv
// Shared definitions for the two's-complement serial deserializer.
package tc_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE,
        RECV
    } state_e;

endpackage

// File: rtl/tc_neg_bit.sv
// One step of serial two's-complement negation: bits are copied through the first 1,
// and every bit after it is inverted.
module tc_neg_bit (
    input  logic i_bit,
    input  logic i_start,
    input  logic i_seen,
    output logic o_nbit
);

    // A start bit opens a new word, so an earlier 1 must not cause inversion.
    assign o_nbit = i_bit ^ (i_seen & ~i_start);

endmodule

// File: rtl/tc_deser.sv
// LSB-first serial deserializer for two's-complement words. Reports the raw word,
// its magnitude, sign and most-negative overflow one cycle after the last bit.
module tc_deser
    import tc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             r,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] mag,
    output logic             neg,
    output logic             ovf,
    output logic             valid,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           r_state, w_state_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;
    logic             r_seen, w_seen_d;
    logic [WIDTH-1:0] r_raw, w_raw_d;
    logic [WIDTH-1:0] r_negw, w_negw_d;
    logic [WIDTH-1:0] r_data, w_data_d;
    logic [WIDTH-1:0] r_mag, w_mag_d;
    logic             r_neg, w_neg_d;
    logic             r_ovf, w_ovf_d;
    logic             r_valid, w_valid_d;
    logic             r_err, w_err_d;
    logic             w_nbit;

    tc_neg_bit u_neg_bit (
        .i_bit   (i),
        .i_start (r),
        .i_seen  (r_seen),
        .o_nbit  (w_nbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_seen  <= 1'b0;
            r_raw   <= '0;
            r_negw  <= '0;
            r_data  <= '0;
            r_mag   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_seen  <= w_seen_d;
            r_raw   <= w_raw_d;
            r_negw  <= w_negw_d;
            r_data  <= w_data_d;
            r_mag   <= w_mag_d;
            r_neg   <= w_neg_d;
            r_ovf   <= w_ovf_d;
            r_valid <= w_valid_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_seen_d  = r_seen;
        w_raw_d   = r_raw;
        w_negw_d  = r_negw;
        w_data_d  = r_data;
        w_mag_d   = r_mag;
        w_neg_d   = r_neg;
        w_ovf_d   = r_ovf;
        w_valid_d = 1'b0;
        w_err_d   = 1'b0;

        if (r) begin
            // Frame start wins in any state; a partial word in RECV is dropped.
            w_raw_d     = '0;
            w_raw_d[0]  = i;
            w_negw_d    = '0;
            w_negw_d[0] = w_nbit;
            w_seen_d    = i;
            w_cnt_d     = CW'(1);
            w_state_d   = RECV;
            w_err_d     = (r_state == RECV);
        end else if (r_state == RECV) begin
            w_raw_d[r_cnt]  = i;
            w_negw_d[r_cnt] = w_nbit;
            w_seen_d        = r_seen | i;
            if (r_cnt == CNT_LAST) begin
                w_data_d  = w_raw_d;
                w_neg_d   = i;
                w_mag_d   = i ? w_negw_d : w_raw_d;
                w_ovf_d   = i && (w_raw_d[WIDTH-2:0] == '0);
                w_valid_d = 1'b1;
                w_cnt_d   = '0;
                w_state_d = IDLE;
            end else begin
                w_cnt_d = r_cnt + CW'(1);
            end
        end
    end

    assign data  = r_data;
    assign mag   = r_mag;
    assign neg   = r_neg;
    assign ovf   = r_ovf;
    assign valid = r_valid;
    assign err   = r_err;

endmodule

// File: doc/tc_deser.md
TC_DESER -- requirements
Module: tc_deser

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the word length in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 i  input  1  SHALL carry the serial two's-complement data bit, LSB first, one bit per clk.
REQ-005 r  input  1  SHALL mark frame start: r=1 qualifies i as bit 0 of a new word.
REQ-006 data  output  WIDTH  SHALL hold the last completed raw word.
REQ-007 mag  output  WIDTH  SHALL hold the magnitude of the last completed word.
REQ-008 neg  output  1  SHALL equal the sign bit (MSB) of the last completed word.
REQ-009 ovf  output  1  SHALL flag that the magnitude is not representable, i.e. the word was the most negative value.
REQ-010 valid  output  1  SHALL pulse high for one cycle when data/mag/neg/ovf update.
REQ-011 err  output  1  SHALL pulse high for one cycle when a frame is aborted.

Function
REQ-012 The block SHALL have states IDLE and RECV, with a bit counter cnt of width clog2(WIDTH).
REQ-013 In IDLE with r=0, i SHALL be ignored and state SHALL hold.
REQ-014 r=1 in any state SHALL load i as bit 0, set cnt=1, and enter RECV, or stay in RECV when WIDTH>1.
REQ-015 In RECV with r=0, i SHALL be shifted in as bit cnt, and cnt SHALL increment.
REQ-016 The block SHALL compute a running negation serially: copy bits up to and including the first 1, then invert every later bit; the seen-one flag SHALL be cleared on each r=1.
REQ-017 On the edge that samples bit WIDTH-1, the block SHALL register data=raw, neg=bit WIDTH-1, mag=(neg ? negated : raw), and ovf=(neg and raw==1 followed by WIDTH-1 zeros), set valid=1 for the next cycle, and return to IDLE.
REQ-018 Latency SHALL be 1 cycle: valid SHALL be high in the cycle immediately after the last bit is sampled.
REQ-019 For the most negative value, mag SHALL equal 1 followed by WIDTH-1 zeros (the unsigned magnitude) and ovf SHALL be 1.
REQ-020 r=1 while in RECV SHALL abort the partial word and pulse err for one cycle; the current bit SHALL start the new frame; data/mag/neg/ovf SHALL keep their prior values.
REQ-021 r=1 in the cycle after the last bit of a frame SHALL start a new frame without err, supporting back-to-back frames.
REQ-022 valid and err SHALL never be high in the same cycle.
REQ-023 data/mag/neg/ovf SHALL hold their values between valid pulses.

Reset
REQ-024 rst=1 SHALL force IDLE, cnt=0, seen-one=0, the shift registers to 0, data=0, mag=0, neg=0, ovf=0, valid=0, and err=0 on the next edge.
REQ-025 rst SHALL take priority over r.
REQ-026 rst mid-frame SHALL discard the partial word without asserting err.

Structure
REQ-027 Package tc_pkg SHALL hold the WIDTH default and the state enum (IDLE, RECV).
REQ-028 Sub-module tc_neg_bit SHALL implement the serial negation step (inputs: bit, start, seen-one state; output: negated bit) and be instantiated once.

Verification (WIDTH=8; bits listed LSB first)
REQ-029 r=1 on the first bit, stream 1,0,1,0,0,0,0,0 (0x05) -> valid 1 cycle later; data=0x05, mag=0x05, neg=0, ovf=0.
REQ-030 Stream 1,1,0,1,1,1,1,1 (0xFB) -> data=0xFB, mag=0x05, neg=1, ovf=0.
REQ-031 Stream 0,0,0,0,0,0,0,1 (0x80) -> data=0x80, mag=0x80, neg=1, ovf=1; the stream 0x00 -> mag=0x00, neg=0.
REQ-032 Four bits of one frame, then r=1 with the stream 0x03 -> err pulses once; then valid with data=0x03; outputs unchanged before that.
REQ-033 Back-to-back frames 0x7F then 0x81, r asserted on consecutive frame starts -> two valid pulses 8 cycles apart; the second gives mag=0x7F, neg=1; no err.
REQ-034 rst asserted at bit 5 of a frame -> all outputs 0 on the next edge; no valid or err; the next full frame decodes correctly.
